// File: rtl/rotation_line_parser_pkg.sv
// -----------------------------------------------------------------------------
// rotation_line_parser_pkg
// Shared definitions for the rotation line parser: ASCII byte constants, the
// parser state encoding and the default accumulator sizing.
// -----------------------------------------------------------------------------
package rotation_line_parser_pkg;

    localparam logic [7:0] CH_L  = 8'h4C;  // 'L' : negative rotation
    localparam logic [7:0] CH_R  = 8'h52;  // 'R' : positive rotation
    localparam logic [7:0] CH_LF = 8'h0A;  // line terminator
    localparam logic [7:0] CH_CR = 8'h0D;  // ignored everywhere
    localparam logic [7:0] CH_SP = 8'h20;  // ignored between lines
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam int DEFAULT_WIDTH_VALUE = 32;
    localparam int DEFAULT_MAX_DIGITS  = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        SKIP   = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/rotation_line_parser_decimal_accumulator.sv
// -----------------------------------------------------------------------------
// decimal_accumulator
// Builds an unsigned decimal magnitude one ASCII digit at a time
// (acc = acc*10 + digit) and counts the digits taken.
//
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   clear       restart: acc and digit count go to zero
//   digit_en    fold 'digit' into the accumulator this cycle
//   digit       decimal digit value 0..9
//   acc         current magnitude, truncated to WIDTH_VALUE
//   ndig_zero   no digit accepted since the last clear
//   full        MAX_DIGITS digits accepted; another digit is an overflow
// -----------------------------------------------------------------------------
module decimal_accumulator
    import rotation_line_parser_pkg::*;
#(
    parameter int WIDTH_VALUE = DEFAULT_WIDTH_VALUE,
    parameter int MAX_DIGITS  = DEFAULT_MAX_DIGITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   digit_en,
    input  logic [3:0]             digit,
    output logic [WIDTH_VALUE-1:0] acc,
    output logic                   ndig_zero,
    output logic                   full
);

    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);

    logic [WIDTH_VALUE-1:0] acc_d, acc_q;
    logic [NDIG_W-1:0]      ndig_d, ndig_q;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_d  = acc_q;
        ndig_d = ndig_q;
        if (clear) begin
            acc_d  = '0;
            ndig_d = '0;
        end else if (digit_en) begin
            // x10 as x8 + x2; wraps silently at WIDTH_VALUE bits.
            acc_d  = (acc_q << 3) + (acc_q << 1)
                   + {{(WIDTH_VALUE-4){1'b0}}, digit};
            ndig_d = ndig_q + NDIG_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            ndig_q <= '0;
        end else begin
            acc_q  <= acc_d;
            ndig_q <= ndig_d;
        end
    end

    assign acc       = acc_q;
    assign ndig_zero = (ndig_q == '0);
    assign full      = (ndig_q == NDIG_W'(MAX_DIGITS));

endmodule

// File: rtl/rotation_line_parser.sv
// -----------------------------------------------------------------------------
// rotation_line_parser
// Parses UART lines such as "L68\n" / "R48\r\n" into a signed delta (L is
// negative) and presents it sign-extended on dout with a one-cycle valid
// pulse, one clock after the terminating '\n'. Counts good and bad lines.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx_byte      received ASCII byte, qualified by rx_valid (no backpressure)
//   dout         last good delta, sign-extended; holds between emissions
//   dout_valid   one-cycle pulse per good line
//   lines_ok     good lines emitted, saturating
//   lines_err    malformed lines, saturating
//   busy         a line is partially received
// -----------------------------------------------------------------------------
module rotation_line_parser
    import rotation_line_parser_pkg::*;
#(
    parameter int WIDTH_DOUT  = 128,
    parameter int WIDTH_VALUE = DEFAULT_WIDTH_VALUE,
    parameter int MAX_DIGITS  = DEFAULT_MAX_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    output logic [WIDTH_DOUT-1:0] dout,
    output logic                  dout_valid,
    output logic [15:0]           lines_ok,
    output logic [15:0]           lines_err,
    output logic                  busy
);

    state_t                  state_d, state_q;
    logic                    neg_d, neg_q;
    logic [WIDTH_DOUT-1:0]   dout_d, dout_q;
    logic                    dout_valid_d, dout_valid_q;
    logic [15:0]             lines_ok_d, lines_ok_q;
    logic [15:0]             lines_err_d, lines_err_q;

    logic                    acc_clear, digit_en, ndig_zero, acc_full;
    logic [WIDTH_VALUE-1:0]  acc;
    logic [WIDTH_VALUE-1:0]  delta;
    logic                    emit, line_err;

    decimal_accumulator #(
        .WIDTH_VALUE (WIDTH_VALUE),
        .MAX_DIGITS  (MAX_DIGITS)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clear),
        .digit_en  (digit_en),
        .digit     (rx_byte[3:0]),  // low nibble of '0'..'9' is the value
        .acc       (acc),
        .ndig_zero (ndig_zero),
        .full      (acc_full)
    );

    // Negation in WIDTH_VALUE bits; -0 is 0, so "L0" emits plain zero.
    assign delta = neg_q ? (~acc + WIDTH_VALUE'(1)) : acc;

    // Next-state / control decode. Only bytes with rx_valid are examined;
    // CR is transparent in every state.
    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        acc_clear = 1'b0;
        digit_en  = 1'b0;
        emit      = 1'b0;
        line_err  = 1'b0;

        if (rx_valid && rx_byte != CH_CR) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte == CH_L || rx_byte == CH_R) begin
                        neg_d     = (rx_byte == CH_L);
                        acc_clear = 1'b1;
                        state_d   = DIGITS;
                    end else if (rx_byte != CH_LF && rx_byte != CH_SP) begin
                        state_d = SKIP;
                    end
                end
                DIGITS: begin
                    if (is_digit(rx_byte)) begin
                        if (acc_full) state_d  = SKIP;
                        else          digit_en = 1'b1;
                    end else if (rx_byte == CH_LF) begin
                        emit     = !ndig_zero;
                        line_err = ndig_zero;
                        state_d  = IDLE;
                    end else begin
                        state_d = SKIP;
                    end
                end
                SKIP: begin
                    if (rx_byte == CH_LF) begin
                        line_err = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Emission and counters are registered, giving the 1-clock latency.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = emit;
        lines_ok_d   = lines_ok_q;
        lines_err_d  = lines_err_q;
        if (emit) begin
            dout_d = {{(WIDTH_DOUT-WIDTH_VALUE){delta[WIDTH_VALUE-1]}}, delta};
            if (lines_ok_q != 16'hFFFF) lines_ok_d = lines_ok_q + 16'd1;
        end
        if (line_err && lines_err_q != 16'hFFFF) lines_err_d = lines_err_q + 16'd1;
    end

    // NOTE: reset is synchronous to match the rest of the UART clock domain;
    // a reset mid-line simply drops the partial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            neg_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            lines_ok_q   <= '0;
            lines_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            neg_q        <= neg_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            lines_ok_q   <= lines_ok_d;
            lines_err_q  <= lines_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign lines_ok   = lines_ok_q;
    assign lines_err  = lines_err_q;
    assign busy       = (state_q != IDLE);

endmodule
